nmr_voter: RTL and testbench

//  Parametrised N-modular-redundancy voter with lane health tracking. Takes LANES replicated

---
 rtl/nmr_pkg.sv | 48 ++++
 rtl/nmr_voter_if.sv | 26 ++
 rtl/nmr_lane_monitor.sv | 68 ++++++
 rtl/nmr_voter.sv | 111 +++++++++++
 tb/tb_nmr_voter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nmr_pkg.sv
// Shared types and bit-level voting helpers for the N-modular-redundancy voter.
// Lane vectors are zero-padded to MAX_LANES so the helpers serve any LANES value.
package nmr_pkg;

    localparam int MAX_LANES = 7;

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        SUSPECT = 2'd1,
        RETIRED = 2'd2
    } lane_state_t;

    function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (v[i]) cnt = cnt + 3'd1;
        end
        return cnt;
    endfunction

    // Strict majority wins; a tie falls back to the lowest-indexed active lane.
    function automatic logic maj_bit(input logic [MAX_LANES-1:0] bits,
                                     input logic [MAX_LANES-1:0] mask);
        logic [2:0] n;
        logic [2:0] k;
        logic       low_bit;
        n       = popcount(mask);
        k       = popcount(bits & mask);
        low_bit = 1'b0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) low_bit = bits[i];
        end
        if ({k, 1'b0} > {1'b0, n})      return 1'b1;
        else if ({k, 1'b0} < {1'b0, n}) return 1'b0;
        else                            return low_bit;
    endfunction

    function automatic logic tie_bit(input logic [MAX_LANES-1:0] bits,
                                     input logic [MAX_LANES-1:0] mask);
        logic [2:0] n;
        logic [2:0] k;
        n = popcount(mask);
        k = popcount(bits & mask);
        return (n != 3'd0) && ({k, 1'b0} == {1'b0, n});
    endfunction

endpackage

// File: rtl/nmr_voter_if.sv
// Bundle of replicated lane inputs and voted/health outputs of the NMR voter.
interface nmr_voter_if #(
    parameter int WIDTH = 27,
    parameter int LANES = 3,
    parameter int CNT_W = 8
);
    logic [LANES*WIDTH-1:0] lane_data;
    logic [LANES-1:0]       err_inj;
    logic                   clr_fault;
    logic [WIDTH-1:0]       data_out;
    logic                   tmr_error;
    logic                   no_majority;
    logic                   degraded;
    logic [LANES-1:0]       lane_active;
    logic [LANES*CNT_W-1:0] lane_err_cnt;

    modport master (
        output lane_data, err_inj, clr_fault,
        input  data_out, tmr_error, no_majority, degraded, lane_active, lane_err_cnt
    );

    modport slave (
        input  lane_data, err_inj, clr_fault,
        output data_out, tmr_error, no_majority, degraded, lane_active, lane_err_cnt
    );
endinterface

// File: rtl/nmr_lane_monitor.sv
// Per-lane health tracker: consecutive-mismatch FSM plus saturating total error count.
// hold comes from the top's keep-one-alive arbitration and vetoes a retirement.
module nmr_lane_monitor
    import nmr_pkg::*;
#(
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_fault,
    input  logic             mismatch,
    input  logic             hold,
    output logic             active,
    output logic             retire_req,
    output logic [CNT_W-1:0] err_cnt
);

    lane_state_t state;
    logic [7:0]  cc;
    logic [8:0]  cc_inc;

    assign cc_inc     = {1'b0, cc} + 9'd1;
    assign active     = (state != RETIRED);
    assign retire_req = mismatch &&
                        (((state == ACTIVE) && (FAULT_THRESH == 1)) ||
                         ((state == SUSPECT) && (cc_inc == 9'(FAULT_THRESH))));

    always_ff @(posedge clk) begin
        if (rst || clr_fault) begin
            state   <= ACTIVE;
            cc      <= 8'd0;
            err_cnt <= '0;
        end else begin
            if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
            case (state)
                ACTIVE: begin
                    if (mismatch) begin
                        if (retire_req) begin
                            state <= hold ? SUSPECT : RETIRED;
                        end else begin
                            state <= SUSPECT;
                            cc    <= 8'd1;
                        end
                    end
                end
                SUSPECT: begin
                    if (mismatch) begin
                        // A held lane keeps its count so it re-requests retirement next time.
                        if (retire_req) begin
                            if (!hold) begin
                                state <= RETIRED;
                                cc    <= cc_inc[7:0];
                            end
                        end else begin
                            cc <= cc_inc[7:0];
                        end
                    end else begin
                        state <= ACTIVE;
                        cc    <= 8'd0;
                    end
                end
                default: state <= RETIRED;
            endcase
        end
    end

endmodule

// File: rtl/nmr_voter.sv
// N-modular-redundancy voter: bitwise vote over healthy lanes, registered outputs,
// and lane retirement that never leaves the vote without at least one lane.
module nmr_voter
    import nmr_pkg::*;
#(
    parameter int WIDTH        = 27,
    parameter int LANES        = 3,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input logic        clk,
    input logic        rst,
    nmr_voter_if.slave bus
);

    logic [WIDTH-1:0]       d [LANES];
    logic [LANES-1:0]       active;
    logic [LANES-1:0]       mismatch;
    logic [LANES-1:0]       retire_req;
    logic [LANES-1:0]       hold;
    logic [LANES-1:0]       next_active;
    logic [MAX_LANES-1:0]   mask_ext;
    logic [MAX_LANES-1:0]   next_ext;
    logic [MAX_LANES-1:0]   bits;
    logic [WIDTH-1:0]       vote;
    logic                   tie_any;
    logic                   all_retire;
    logic [LANES*CNT_W-1:0] err_cnt_all;

    logic [WIDTH-1:0]       data_out_p1;
    logic                   tmr_error_p1;
    logic                   no_majority_p1;
    logic                   degraded_p1;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            d[i] = bus.lane_data[i*WIDTH +: WIDTH] ^ {WIDTH{bus.err_inj[i]}};
        end
    end

    always_comb begin
        mask_ext              = '0;
        mask_ext[LANES-1:0]   = active;
        next_ext              = '0;
        next_ext[LANES-1:0]   = next_active;
    end

    always_comb begin
        vote    = '0;
        tie_any = 1'b0;
        bits    = '0;
        for (int b = 0; b < WIDTH; b++) begin
            bits = '0;
            for (int i = 0; i < LANES; i++) bits[i] = d[i][b];
            vote[b] = maj_bit(bits, mask_ext);
            tie_any = tie_any | tie_bit(bits, mask_ext);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mismatch[i] = active[i] && (d[i] != vote);
        end
    end

    // If every active lane would retire at once, spare the lowest-indexed one.
    always_comb begin
        all_retire  = (active != '0) && ((retire_req & active) == active);
        hold        = all_retire ? (retire_req & (~retire_req + LANES'(1))) : '0;
        next_active = bus.clr_fault ? '1 : (active & ~(retire_req & ~hold));
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        nmr_lane_monitor #(
            .FAULT_THRESH (FAULT_THRESH),
            .CNT_W        (CNT_W)
        ) u_mon (
            .clk        (clk),
            .rst        (rst),
            .clr_fault  (bus.clr_fault),
            .mismatch   (mismatch[g]),
            .hold       (hold[g]),
            .active     (active[g]),
            .retire_req (retire_req[g]),
            .err_cnt    (err_cnt_all[g*CNT_W +: CNT_W])
        );
    end

    // Stage p1: registered vote and health flags
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_p1    <= '0;
            tmr_error_p1   <= 1'b0;
            no_majority_p1 <= 1'b0;
            degraded_p1    <= 1'b0;
        end else begin
            data_out_p1    <= vote;
            tmr_error_p1   <= |mismatch;
            no_majority_p1 <= tie_any;
            degraded_p1    <= (popcount(next_ext) < 3'(LANES));
        end
    end

    assign bus.data_out     = data_out_p1;
    assign bus.tmr_error    = tmr_error_p1;
    assign bus.no_majority  = no_majority_p1;
    assign bus.degraded     = degraded_p1;
    assign bus.lane_active  = active;
    assign bus.lane_err_cnt = err_cnt_all;

endmodule

// File: tb/tb_nmr_voter.sv
// Bench for nmr_voter: a count-based behavioural model checked every cycle on two
// instances (8-bit and 2-bit error counters), plus directed literal expectations.
module tb_nmr_voter;
    import nmr_pkg::*;

    localparam int WIDTH  = 27;
    localparam int LANES  = 3;
    localparam int THRESH = 4;
    localparam logic [WIDTH-1:0] P = 27'h1234567;

    logic clk = 1'b0;
    logic rst;
    logic [LANES*WIDTH-1:0] ld;
    logic [LANES-1:0]       inj;
    logic                   clr;

    always #5 clk = ~clk;

    nmr_voter_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(8)) if8 ();
    nmr_voter_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(2)) if2 ();

    assign if8.lane_data = ld;
    assign if8.err_inj   = inj;
    assign if8.clr_fault = clr;
    assign if2.lane_data = ld;
    assign if2.err_inj   = inj;
    assign if2.clr_fault = clr;

    nmr_voter #(.WIDTH(WIDTH), .LANES(LANES), .FAULT_THRESH(THRESH), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    nmr_voter #(.WIDTH(WIDTH), .LANES(LANES), .FAULT_THRESH(THRESH), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: lane health as a consecutive-mismatch count and an active flag.
    bit               m_act  [LANES];
    int               m_cc   [LANES];
    int               m_cnt8 [LANES];
    int               m_cnt2 [LANES];
    logic [WIDTH-1:0] e_data;
    bit               e_tmr, e_nomaj, e_deg;

    task automatic model_step();
        logic [WIDTH-1:0] dd [LANES];
        logic [WIDTH-1:0] v;
        bit               mm [LANES];
        bit               ret [LANES];
        int               newcc [LANES];
        int               n, k, low, survivors, cnt_act;
        bit               tie;
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                m_act[i] = 1; m_cc[i] = 0; m_cnt8[i] = 0; m_cnt2[i] = 0;
            end
            e_data = '0; e_tmr = 0; e_nomaj = 0; e_deg = 0;
            return;
        end
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            dd[i] = ld[i*WIDTH +: WIDTH] ^ {WIDTH{inj[i]}};
            if (m_act[i]) n++;
        end
        tie = 0;
        v   = '0;
        for (int b = 0; b < WIDTH; b++) begin
            k = 0; low = -1;
            for (int i = 0; i < LANES; i++) begin
                if (m_act[i]) begin
                    if (low < 0) low = i;
                    if (dd[i][b]) k++;
                end
            end
            if (2 * k > n)      v[b] = 1'b1;
            else if (2 * k < n) v[b] = 1'b0;
            else begin
                v[b] = (low >= 0) ? dd[low][b] : 1'b0;
                tie  = 1;
            end
        end
        e_tmr = 0;
        for (int i = 0; i < LANES; i++) begin
            mm[i] = m_act[i] && (dd[i] != v);
            if (mm[i]) e_tmr = 1;
        end
        e_data  = v;
        e_nomaj = tie;
        if (clr) begin
            for (int i = 0; i < LANES; i++) begin
                m_act[i] = 1; m_cc[i] = 0; m_cnt8[i] = 0; m_cnt2[i] = 0;
            end
        end else begin
            survivors = 0;
            for (int i = 0; i < LANES; i++) begin
                ret[i]   = 0;
                newcc[i] = m_cc[i];
                if (mm[i]) begin
                    if (m_cnt8[i] < 255) m_cnt8[i]++;
                    if (m_cnt2[i] < 3)   m_cnt2[i]++;
                    newcc[i] = m_cc[i] + 1;
                    ret[i]   = (newcc[i] >= THRESH);
                end else if (m_act[i]) begin
                    newcc[i] = 0;
                end
                if (m_act[i] && !ret[i]) survivors++;
            end
            if (survivors == 0) begin
                for (int i = 0; i < LANES; i++) begin
                    if (m_act[i]) begin
                        ret[i]   = 0;
                        newcc[i] = m_cc[i];
                        break;
                    end
                end
            end
            for (int i = 0; i < LANES; i++) begin
                m_cc[i] = newcc[i];
                if (ret[i]) m_act[i] = 0;
            end
        end
        cnt_act = 0;
        for (int i = 0; i < LANES; i++) if (m_act[i]) cnt_act++;
        e_deg = (cnt_act < LANES);
    endtask

    task automatic compare_all();
        logic [LANES-1:0] pa;
        for (int i = 0; i < LANES; i++) pa[i] = m_act[i];
        check("data_out",     if8.data_out,    e_data);
        check("tmr_error",    if8.tmr_error,   e_tmr);
        check("no_majority",  if8.no_majority, e_nomaj);
        check("degraded",     if8.degraded,    e_deg);
        check("lane_active",  if8.lane_active, pa);
        check("data_out_c2",  if2.data_out,    e_data);
        check("lane_active_c2", if2.lane_active, pa);
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("err_cnt8[%0d]", i), if8.lane_err_cnt[i*8 +: 8], 64'(m_cnt8[i]));
            check($sformatf("err_cnt2[%0d]", i), if2.lane_err_cnt[i*2 +: 2], 64'(m_cnt2[i]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    end

    task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [LANES-1:0] i,
                        input logic cl, input logic r);
        ld  = {c, b, a};
        inj = i;
        clr = cl;
        rst = r;
        @(negedge clk);
    endtask

    initial begin
        step(P, P, P, 3'b000, 1'b0, 1'b1);
        step(P, P, P, 3'b000, 1'b0, 1'b1);
        check("rst_data",   if8.data_out,     27'h0);
        check("rst_active", if8.lane_active,  3'b111);
        check("rst_deg",    if8.degraded,     1'b0);
        check("rst_cnt",    if8.lane_err_cnt, 24'h0);

        step(P, P, P, 3'b000, 1'b0, 1'b0);
        check("t1_data",   if8.data_out,    P);
        check("t1_tmr",    if8.tmr_error,   1'b0);
        check("t1_active", if8.lane_active, 3'b111);

        step(P, P, P, 3'b010, 1'b0, 1'b0);
        check("t2_data", if8.data_out,              P);
        check("t2_tmr",  if8.tmr_error,             1'b1);
        check("t2_cnt1", if8.lane_err_cnt[15:8],    8'd1);
        step(P, P, P, 3'b000, 1'b0, 1'b0);
        check("t2_tmr_clear", if8.tmr_error,   1'b0);
        check("t2_active",    if8.lane_active, 3'b111);

        repeat (3) step(P, P, P, 3'b010, 1'b0, 1'b0);
        check("t3_not_yet", if8.lane_active, 3'b111);
        step(P, P, P, 3'b010, 1'b0, 1'b0);
        check("t3_active",  if8.lane_active,       3'b101);
        check("t3_deg",     if8.degraded,          1'b1);
        check("t3_cnt2sat", if2.lane_err_cnt[3:2], 2'd3);
        check("t3_cnt8",    if8.lane_err_cnt[15:8], 8'd5);
        step(27'h1234566, P, P, 3'b000, 1'b0, 1'b0);
        check("t3_tie_data", if8.data_out,    27'h1234566);
        check("t3_nomaj",    if8.no_majority, 1'b1);
        step(P, P, P, 3'b000, 1'b0, 1'b0);
        check("t3_nomaj_clear", if8.no_majority, 1'b0);

        repeat (3) step(P, P, P, 3'b100, 1'b0, 1'b0);
        check("t4_not_yet", if8.lane_active, 3'b101);
        step(P, P, P, 3'b100, 1'b0, 1'b0);
        check("t4_active", if8.lane_active, 3'b001);
        check("t4_data",   if8.data_out,    P);
        step(27'h0ABCDEF, 27'h5555555, 27'h2AAAAAA, 3'b000, 1'b0, 1'b0);
        check("t4_sole",     if8.data_out,  27'h0ABCDEF);
        check("t4_sole_tmr", if8.tmr_error, 1'b0);
        step(27'h0ABCDEF, 27'h5555555, 27'h2AAAAAA, 3'b001, 1'b0, 1'b0);
        check("t4_sole_inj", if8.data_out,  27'h7543210);

        step(27'h0000001, 27'h0000002, 27'h0000002, 3'b000, 1'b1, 1'b0);
        check("clr_vote",   if8.data_out,     27'h0000001);
        check("clr_active", if8.lane_active,  3'b111);
        check("clr_deg",    if8.degraded,     1'b0);
        check("clr_cnt",    if8.lane_err_cnt, 24'h0);

        repeat (5) begin
            step(P, P, P, 3'b100, 1'b0, 1'b0);
            step(P, P, P, 3'b000, 1'b0, 1'b0);
        end
        check("t5_cnt2", if2.lane_err_cnt[5:4],   2'd3);
        check("t5_cnt8", if8.lane_err_cnt[23:16], 8'd5);
        check("t5_active", if8.lane_active,       3'b111);
        step(P, P, P, 3'b000, 1'b1, 1'b0);
        check("t5_clr_cnt2",   if2.lane_err_cnt, 6'h0);
        check("t5_clr_active", if2.lane_active,  3'b111);
        check("t5_clr_deg",    if2.degraded,     1'b0);

        repeat (3) step(27'h0000001, 27'h0000002, 27'h0000004, 3'b000, 1'b0, 1'b0);
        check("ka_data",   if8.data_out,    27'h0);
        check("ka_tmr",    if8.tmr_error,   1'b1);
        check("ka_active3", if8.lane_active, 3'b111);
        step(27'h0000001, 27'h0000002, 27'h0000004, 3'b000, 1'b0, 1'b0);
        check("ka_active", if8.lane_active,  3'b001);
        check("ka_deg",    if8.degraded,     1'b1);
        check("ka_cnt",    if8.lane_err_cnt, {8'd4, 8'd4, 8'd4});
        step(27'h0000001, 27'h0000002, 27'h0000004, 3'b000, 1'b0, 1'b0);
        check("ka_pass",   if8.data_out,    27'h0000001);
        check("ka_pass_tmr", if8.tmr_error, 1'b0);

        step(P, 27'h0000003, P, 3'b010, 1'b1, 1'b1);
        check("t6_data",   if8.data_out,     27'h0);
        check("t6_tmr",    if8.tmr_error,    1'b0);
        check("t6_nomaj",  if8.no_majority,  1'b0);
        check("t6_deg",    if8.degraded,     1'b0);
        check("t6_active", if8.lane_active,  3'b111);
        check("t6_cnt",    if8.lane_err_cnt, 24'h0);
        step(P, P, P, 3'b000, 1'b0, 1'b0);
        check("t6_resume", if8.data_out, P);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
